// File: rtl/vc_arb_pkg.sv
// vc_arb_pkg: wrap-aware age compare, rotating rank compare and clog2 helper for the VC arbiter
package vc_arb_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // a is older than b when the modular difference a-b has its top bit set
    function automatic logic older(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [31:0] d;
        d = a - b;
        return ((d >> (w - 1)) & 32'd1) == 32'd1;
    endfunction

    function automatic int rank(input int idx, input int ptr, input int n);
        return (idx >= ptr) ? idx - ptr : idx + n - ptr;
    endfunction

    function automatic logic rank_lt(input int a, input int b, input int ptr, input int n);
        return rank(a, ptr, n) < rank(b, ptr, n);
    endfunction

endpackage

// File: rtl/vc_arb_cell.sv
// vc_arb_cell: one tree node, forwards the older of two candidates, ties going to the lower rotating rank
module vc_arb_cell
    import vc_arb_pkg::*;
#(
    parameter int NUM_VC         = 6,
    parameter int TIME_WIDTH     = 8,
    parameter int VC_INDEX_WIDTH = 4
) (
    input  logic                      a_valid,
    input  logic [TIME_WIDTH-1:0]     a_time,
    input  logic [VC_INDEX_WIDTH-1:0] a_idx,
    input  logic                      b_valid,
    input  logic [TIME_WIDTH-1:0]     b_time,
    input  logic [VC_INDEX_WIDTH-1:0] b_idx,
    input  logic [VC_INDEX_WIDTH-1:0] ptr,
    output logic                      w_valid,
    output logic [TIME_WIDTH-1:0]     w_time,
    output logic [VC_INDEX_WIDTH-1:0] w_idx
);
    logic pick_b;
    // b takes the slot only when valid and either a is empty, b is older, or the tie favours b's rank
    always_comb begin
        pick_b = b_valid && (!a_valid || older(32'(b_time), 32'(a_time), TIME_WIDTH) ||
                 (b_time == a_time && rank_lt(int'(b_idx), int'(a_idx), int'(ptr), NUM_VC)));
        w_valid = a_valid || b_valid;
        w_time  = pick_b ? b_time : a_time;
        w_idx   = pick_b ? b_idx : a_idx;
    end
endmodule

// File: rtl/vc_arb_nto1_pipe.sv
// vc_arb_nto1_pipe: pipelined oldest-timestamp arbiter over NUM_VC VCs; define VC_ARB_RR_TIE_EN for a rotating tie-break
`ifndef TIME_WIDTH
`define TIME_WIDTH 8
`endif
`ifndef VC_INDEX_WIDTH
`define VC_INDEX_WIDTH 4
`endif
module vc_arb_nto1_pipe
    import vc_arb_pkg::*;
#(
    parameter int NUM_VC         = 6,
    parameter int TIME_WIDTH     = `TIME_WIDTH,
    parameter int VC_INDEX_WIDTH = `VC_INDEX_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_VC-1:0]            vc_valid,
    input  logic [NUM_VC*TIME_WIDTH-1:0] time_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         winner_found,
    output logic [VC_INDEX_WIDTH-1:0]    winner_vc_out,
    output logic [TIME_WIDTH-1:0]        winner_time_out
);
    localparam int LEVELS = clog2(NUM_VC);

    typedef struct packed {
        logic                      valid;
        logic [TIME_WIDTH-1:0]     t;
        logic [VC_INDEX_WIDTH-1:0] idx;
    } node_t;

    node_t                     src  [LEVELS][NUM_VC];
    node_t                     nxt  [LEVELS][NUM_VC];
    node_t                     stg  [LEVELS][NUM_VC];
    logic [VC_INDEX_WIDTH-1:0] psrc [LEVELS];
    logic [LEVELS-1:0]         v;
    logic [LEVELS-1:0]         ld;

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int N = (NUM_VC + (1 << k) - 1) >> k;
        for (genvar j = 0; j < NUM_VC; j++) begin : g_node
            if (k == 0) begin : g_in
                assign src[0][j] = vc_valid[j] ? {1'b1, time_in[j*TIME_WIDTH +: TIME_WIDTH], VC_INDEX_WIDTH'(j)} : '0;
            end else begin : g_stage
                assign src[k][j] = stg[k-1][j];
            end
            if (2*j + 1 < N) begin : g_cell
                vc_arb_cell #(
                    .NUM_VC(NUM_VC),
                    .TIME_WIDTH(TIME_WIDTH),
                    .VC_INDEX_WIDTH(VC_INDEX_WIDTH)
                ) u_cell (
                    .a_valid(src[k][2*j].valid),
                    .a_time (src[k][2*j].t),
                    .a_idx  (src[k][2*j].idx),
                    .b_valid(src[k][2*j+1].valid),
                    .b_time (src[k][2*j+1].t),
                    .b_idx  (src[k][2*j+1].idx),
                    .ptr    (psrc[k]),
                    .w_valid(nxt[k][j].valid),
                    .w_time (nxt[k][j].t),
                    .w_idx  (nxt[k][j].idx)
                );
            end else if (2*j < N) begin : g_pass
                assign nxt[k][j] = src[k][2*j];
            end else begin : g_zero
                assign nxt[k][j] = '0;
            end
        end
    end

    // a stage reloads when empty or when everything downstream of it is moving; the tail moves on out_ready
    always_comb begin
        logic c;
        c = out_ready;
        for (int i = LEVELS - 1; i >= 0; i--) begin
            c = c || !v[i];
            ld[i] = c;
        end
    end

    // pipeline registers: valid bit and node row per stage
    always_ff @(posedge clk) begin
        if (reset) begin
            v <= '0;
            for (int i = 0; i < LEVELS; i++)
                for (int j = 0; j < NUM_VC; j++) stg[i][j] <= '0;
        end else begin
            for (int i = 0; i < LEVELS; i++) begin
                if (ld[i]) begin
                    v[i]   <= (i == 0) ? in_valid : v[(i == 0) ? 0 : i - 1];
                    stg[i] <= nxt[i];
                end
            end
        end
    end

`ifdef VC_ARB_RR_TIE_EN
    logic [VC_INDEX_WIDTH-1:0] rr_ptr;
    logic [VC_INDEX_WIDTH-1:0] ptr_q [LEVELS];

    // each stage keeps the pointer its vector saw at accept; the live pointer steps past every granted winner
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
            for (int i = 0; i < LEVELS; i++) ptr_q[i] <= '0;
        end else begin
            if (out_valid && out_ready && winner_found)
                rr_ptr <= (int'(winner_vc_out) == NUM_VC - 1) ? '0 : winner_vc_out + 1'b1;
            for (int i = 0; i < LEVELS; i++)
                if (ld[i]) ptr_q[i] <= psrc[i];
        end
    end

    // the first level compares against the live pointer, deeper levels against the one stored with the vector
    always_comb begin
        psrc[0] = rr_ptr;
        for (int i = 1; i < LEVELS; i++) psrc[i] = ptr_q[i-1];
    end
`else
    assign psrc = '{default: '0};
`endif

    assign in_ready        = ld[0];
    assign out_valid       = v[LEVELS-1];
    assign winner_found    = stg[LEVELS-1][0].valid;
    assign winner_vc_out   = stg[LEVELS-1][0].idx;
    assign winner_time_out = stg[LEVELS-1][0].t;
endmodule
